// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and default pipeline stage indices
package hazard_pkg;
    typedef enum logic {IDLE, PENDING} state_t;
    localparam int IFP = 0;
    localparam int IFR = 1;
    localparam int IDR = 2;
    localparam int IDP = 3;
    localparam int IDC = 4;
    localparam int EXA = 5;
    localparam int EXB = 6;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard inputs, redirect handshake and stall/flush/counter outputs
interface hazard_ctrl_if #(
    parameter int NUM_STAGES = 7,
    parameter int XLEN = 64,
    parameter int CNT_W = 32
);
    logic                  redirect_valid_i;
    logic [XLEN-1:0]       redirect_target_i;
    logic                  load_use_i;
    logic [NUM_STAGES-1:0] busy_i;
    logic                  fetch_ready_i;
    logic                  cnt_clear_i;
    logic [NUM_STAGES-1:0] stall_o;
    logic [NUM_STAGES-1:0] flush_o;
    logic                  redirect_o;
    logic [XLEN-1:0]       redirect_target_o;
    logic [CNT_W-1:0]      stall_cnt_o;
    logic [CNT_W-1:0]      flush_cnt_o;
    modport master (
        output redirect_valid_i, redirect_target_i, load_use_i, busy_i, fetch_ready_i, cnt_clear_i,
        input  stall_o, flush_o, redirect_o, redirect_target_o, stall_cnt_o, flush_cnt_o
    );
    modport slave (
        input  redirect_valid_i, redirect_target_i, load_use_i, busy_i, fetch_ready_i, cnt_clear_i,
        output stall_o, flush_o, redirect_o, redirect_target_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: event counter that saturates at all-ones; clear wins over increment
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= clr ? '0 : (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: per-stage stall/flush generation, redirect hold-until-fetch-ready FSM
// and saturating stall/flush performance counters
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_STAGES = 7,
    parameter int XLEN = 64,
    parameter int REDIRECT_STAGE = EXB,
    parameter int LU_STAGE = IDP,
    parameter int CNT_W = 32
) (
    input logic        clk,
    input logic        rst_n,
    hazard_ctrl_if.slave bus
);
    state_t                state, state_d;
    logic [XLEN-1:0]       tgt_q, tgt_d;
    logic [NUM_STAGES-1:0] stall_base, flush_base, young, mid;
    logic                  accept, kill;
    int                    d;
    always_comb begin
        d = -1;
        for (int s = 0; s < NUM_STAGES; s++) if (bus.busy_i[s]) d = s;
        if (bus.load_use_i && LU_STAGE > d) d = LU_STAGE;
        for (int s = 0; s < NUM_STAGES; s++) begin
            stall_base[s] = s <= d;
            flush_base[s] = d >= 0 && s == d + 1;
            young[s]      = s < REDIRECT_STAGE;
            mid[s]        = s >= 1 && s < REDIRECT_STAGE;
        end
    end
    assign accept = bus.redirect_valid_i && !stall_base[REDIRECT_STAGE];
    // a pending redirect keeps squashing the younger stages until fetch takes it
    assign kill = accept || state == PENDING;
    assign bus.stall_o = kill ? stall_base & ~young : stall_base;
    assign bus.flush_o = flush_base | (kill ? mid : '0);
    assign bus.redirect_o = kill;
    assign bus.redirect_target_o = accept ? bus.redirect_target_i : state == PENDING ? tgt_q : '0;
    always_comb begin
        tgt_d   = accept ? bus.redirect_target_i : tgt_q;
        state_d = kill && !bus.fetch_ready_i ? PENDING : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            tgt_q <= '0;
        end else begin
            state <= state_d;
            tgt_q <= tgt_d;
        end
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst_n(rst_n), .inc(bus.stall_o[0]), .clr(bus.cnt_clear_i), .cnt(bus.stall_cnt_o)
    );
    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk(clk), .rst_n(rst_n), .inc(accept), .clr(bus.cnt_clear_i), .cnt(bus.flush_cnt_o)
    );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of stall/flush vectors, redirect FSM and counters
module tb_hazard_ctrl;
    logic clk = 0;
    logic rst_n = 0;
    int checks = 0;
    int errors = 0;
    hazard_ctrl_if #(.NUM_STAGES(7), .XLEN(64), .CNT_W(4)) bus ();
    hazard_ctrl #(.NUM_STAGES(7), .XLEN(64), .REDIRECT_STAGE(6), .LU_STAGE(3), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic v, input logic [63:0] t, input logic lu, input logic [6:0] b, input logic fr);
        bus.redirect_valid_i  = v;
        bus.redirect_target_i = t;
        bus.load_use_i        = lu;
        bus.busy_i            = b;
        bus.fetch_ready_i     = fr;
        #1;
    endtask
    initial begin
        bus.cnt_clear_i = 0;
        drive(0, 0, 0, 0, 0);
        chk("rst_stall", 64'(bus.stall_o), 0);
        chk("rst_flush", 64'(bus.flush_o), 0);
        chk("rst_redir", 64'(bus.redirect_o), 0);
        chk("rst_tgt", bus.redirect_target_o, 0);
        chk("rst_scnt", 64'(bus.stall_cnt_o), 0);
        chk("rst_fcnt", 64'(bus.flush_cnt_o), 0);
        cyc();
        rst_n = 1;
        drive(0, 0, 1, 0, 0);
        chk("lu_stall", 64'(bus.stall_o), 64'b0001111);
        chk("lu_flush", 64'(bus.flush_o), 64'b0010000);
        chk("lu_redir", 64'(bus.redirect_o), 0);
        cyc();
        chk("lu_scnt1", 64'(bus.stall_cnt_o), 1);
        cyc();
        chk("lu_scnt2", 64'(bus.stall_cnt_o), 2);
        drive(0, 0, 1, 7'b0100000, 0);
        chk("busy_stall", 64'(bus.stall_o), 64'b0111111);
        chk("busy_flush", 64'(bus.flush_o), 64'b1000000);
        cyc();
        chk("busy_scnt", 64'(bus.stall_cnt_o), 3);
        drive(1, 64'h8000_0100, 1, 0, 1);
        chk("rd_redir", 64'(bus.redirect_o), 1);
        chk("rd_tgt", bus.redirect_target_o, 64'h8000_0100);
        chk("rd_flush", 64'(bus.flush_o), 64'b0111110);
        chk("rd_stall", 64'(bus.stall_o), 0);
        cyc();
        chk("rd_fcnt", 64'(bus.flush_cnt_o), 1);
        chk("rd_scnt", 64'(bus.stall_cnt_o), 3);
        drive(1, 64'h8000_0100, 0, 0, 0);
        chk("pa_redir", 64'(bus.redirect_o), 1);
        chk("pa_flush", 64'(bus.flush_o), 64'b0111110);
        cyc();
        drive(0, 0, 0, 0, 0);
        chk("pb_redir", 64'(bus.redirect_o), 1);
        chk("pb_tgt", bus.redirect_target_o, 64'h8000_0100);
        chk("pb_flush", 64'(bus.flush_o), 64'b0111110);
        chk("pb_fcnt", 64'(bus.flush_cnt_o), 2);
        cyc();
        chk("pc_redir", 64'(bus.redirect_o), 1);
        chk("pc_tgt", bus.redirect_target_o, 64'h8000_0100);
        cyc();
        drive(0, 0, 0, 0, 1);
        chk("pd_redir", 64'(bus.redirect_o), 1);
        chk("pd_tgt", bus.redirect_target_o, 64'h8000_0100);
        cyc();
        drive(0, 0, 0, 0, 0);
        chk("pe_idle_redir", 64'(bus.redirect_o), 0);
        chk("pe_idle_flush", 64'(bus.flush_o), 0);
        drive(1, 64'h8000_0100, 0, 0, 0);
        cyc();
        drive(1, 64'h8000_0200, 0, 0, 0);
        chk("ow_tgt_new", bus.redirect_target_o, 64'h8000_0200);
        chk("ow_redir", 64'(bus.redirect_o), 1);
        cyc();
        drive(0, 0, 0, 0, 0);
        chk("ow_tgt_latched", bus.redirect_target_o, 64'h8000_0200);
        chk("ow_fcnt", 64'(bus.flush_cnt_o), 4);
        drive(0, 0, 0, 0, 1);
        cyc();
        drive(0, 0, 0, 0, 0);
        chk("ow_idle_redir", 64'(bus.redirect_o), 0);
        drive(1, 64'h8000_0300, 0, 7'b1000000, 1);
        chk("blk_redir", 64'(bus.redirect_o), 0);
        chk("blk_stall", 64'(bus.stall_o), 64'b1111111);
        chk("blk_flush", 64'(bus.flush_o), 0);
        cyc();
        chk("blk_fcnt", 64'(bus.flush_cnt_o), 4);
        chk("blk_scnt", 64'(bus.stall_cnt_o), 4);
        drive(1, 64'h8000_0400, 0, 0, 0);
        cyc();
        drive(0, 0, 0, 0, 0);
        chk("rp_redir", 64'(bus.redirect_o), 1);
        chk("rp_fcnt", 64'(bus.flush_cnt_o), 5);
        rst_n = 0;
        #1;
        chk("rp_rst_redir", 64'(bus.redirect_o), 0);
        chk("rp_rst_tgt", bus.redirect_target_o, 0);
        chk("rp_rst_flush", 64'(bus.flush_o), 0);
        chk("rp_rst_scnt", 64'(bus.stall_cnt_o), 0);
        chk("rp_rst_fcnt", 64'(bus.flush_cnt_o), 0);
        cyc();
        rst_n = 1;
        drive(0, 0, 1, 0, 0);
        repeat (20) cyc();
        chk("sat_scnt", 64'(bus.stall_cnt_o), 15);
        cyc();
        chk("sat_hold", 64'(bus.stall_cnt_o), 15);
        bus.cnt_clear_i = 1;
        cyc();
        chk("clr_prio", 64'(bus.stall_cnt_o), 0);
        bus.cnt_clear_i = 0;
        cyc();
        chk("clr_resume", 64'(bus.stall_cnt_o), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the in-order core, sitting beside the fetch/decode/execute stage registers. It issues per-stage stall and flush vectors for load-use and multi-cycle busy hazards. It accepts branch/jump redirects from a configurable resolve stage and holds a redirect pending until fetch can take it. Saturating stall and flush event counters feed the performance CSRs.

## Interface
Parameters:
- NUM_STAGES, 7: pipeline stages, index 0 = IFP (youngest), ascending toward EXB.
- XLEN, 64: redirect target width.
- REDIRECT_STAGE, 6: stage that resolves branches (EXB); range 2..NUM_STAGES-1.
- LU_STAGE, 3: stage that detects load-use (IDP); must be < REDIRECT_STAGE.
- CNT_W, 32: counter width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- redirect_valid_i  in  1  branch taken at REDIRECT_STAGE.
- redirect_target_i  in  XLEN  redirect PC.
- load_use_i  in  1  no forwarding path available for the instruction at LU_STAGE.
- busy_i  in  NUM_STAGES  bit s: stage s cannot advance (multi-cycle unit, cache miss).
- fetch_ready_i  in  1  IFP can accept a redirect this cycle.
- cnt_clear_i  in  1  synchronous clear of both counters.
- stall_o  out  NUM_STAGES  bit s: hold stage s register.
- flush_o  out  NUM_STAGES  bit s: load bubble into stage s register.
- redirect_o  out  1  redirect to IFP.
- redirect_target_o  out  XLEN  redirect PC to IFP.
- stall_cnt_o  out  CNT_W  cycles with stall_o[0]=1.
- flush_cnt_o  out  CNT_W  accepted redirects.

## Operation
- Stall depth D = highest s with busy_i[s]=1, or LU_STAGE if load_use_i and that is higher; no hazard means no D.
- stall_o[s]=1 for s<=D; flush_o[D+1]=1 (bubble) when D+1<NUM_STAGES.
- A redirect is accepted when redirect_valid_i=1 and stall_o[REDIRECT_STAGE]=0. If that stage is stalled, the redirect is ignored and the source must hold it.
- On an accepted redirect, flush_o[s]=1 and stall_o[s]=0 for 1<=s<REDIRECT_STAGE; flush overrides load-use and busy stalls in those stages. Stalls at s>=REDIRECT_STAGE are kept.
- FSM, state in hazard_pkg:
  - IDLE: on accepted redirect with fetch_ready_i=1, redirect_o=1 and redirect_target_o=redirect_target_i in the same cycle, stay in IDLE. With fetch_ready_i=0, latch the target and go to PENDING.
  - PENDING: redirect_o=1, redirect_target_o=latched target. flush_o[s]=1 for 1<=s<REDIRECT_STAGE every cycle. Go to IDLE in the cycle fetch_ready_i=1. A new accepted redirect overwrites the latched target; the newest wins.
- Counters saturate at all-ones. cnt_clear_i has priority over increment.

## Timing
- stall_o, flush_o and IDLE-state redirect outputs are combinational from inputs with zero latency. PENDING outputs come from registers.
- Reset (rst_n low, asynchronous): state=IDLE, latched target=0, both counters=0. Outputs are then purely input-driven; with all inputs 0, every output is 0.
- Reset asserted mid-PENDING drops the pending redirect immediately.
- A redirect in the cycle PENDING exits with fetch_ready_i=1 is forwarded combinationally; the FSM stays in IDLE.
- flush_cnt_o increments once per accepted redirect, including overwrites in PENDING.

## Structure
- hazard_pkg: state enum {IDLE, PENDING}, default stage index localparams (IFP=0, IFR=1, IDR=2, IDP=3, IDC=4, EXA=5, EXB=6).
- Sub-module sat_counter (CNT_W, inc, clr), instantiated twice.
- Stall-depth priority encoder inline.

## Test plan
- load_use_i=1, no busy -> stall_o=7'b0001111, flush_o=7'b0010000, stall_cnt_o increments by 1 per cycle.
- busy_i=7'b0100000 and load_use_i=1 -> stall_o=7'b0111111, flush_o=7'b1000000.
- redirect_valid_i=1, target=64'h8000_0100, fetch_ready_i=1, load_use_i=1 -> redirect_o=1 same cycle, flush_o=7'b0111110, stall_o=0, flush_cnt_o=1.
- redirect with fetch_ready_i=0 for 3 cycles, then 1 -> redirect_o held 4 cycles with target 64'h8000_0100, FSM returns to IDLE.
- busy_i[6]=1 with redirect_valid_i=1 -> redirect ignored, flush_cnt_o unchanged, stall_o=7'b1111111.
- rst_n low during PENDING -> redirect_o=0 immediately, counters=0. Counter at all-ones plus stall -> stays all-ones.
